// File: rtl/sn76489_cmd_writer_if.sv
// Request and PSG-port signal bundle for the SN76489 write sequencer.
// master = host/bench side, slave = sequencer side.
interface sn76489_cmd_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_ch;
    logic       req_att;
    logic [9:0] req_val;
    logic       clk_en;
    logic [7:0] psg_d;
    logic       psg_we;
    logic       busy;

    modport master (
        output req_valid, req_ch, req_att, req_val, clk_en,
        input  req_ready, psg_d, psg_we, busy
    );

    modport slave (
        input  req_valid, req_ch, req_att, req_val, clk_en,
        output req_ready, psg_d, psg_we, busy
    );
endinterface

// File: rtl/sn76489_cmd_writer.sv
// Purpose: queue SN76489 register updates and emit latch/data bytes with an inter-write gap.
// Latency: push in cycle N, pop in N+1, psg_we high in N+2; each byte held until a clk_en tick.
// Backpressure: req_ready registered from FIFO occupancy; PSG side stalls on clk_en low, no loss.
module sn76489_cmd_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_TICKS  = 32,
    parameter int SKIP_HI    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sn76489_cmd_writer_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    typedef struct packed {
        logic [1:0] ch;
        logic       att;
        logic [9:0] val;
    } req_t;

    typedef enum logic [1:0] {IDLE, LATCH, DATA, GAP} state_t;

    req_t            mem [FIFO_DEPTH];
    req_t            head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            ready_q;
    logic            push;
    logic            pop;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   gap_cnt;
    logic [GW-1:0]   gap_next;
    logic            we_q;
    logic            we_next;
    logic [7:0]      d_q;
    logic [7:0]      d_next;

    logic [1:0]      work_ch;
    logic [5:0]      work_hi;
    logic            work_tone;
    logic            need_data;
    logic            shadow_wr;
    logic [3:0]      shadow_valid;
    logic [3:0][5:0] shadow_hi;

    function automatic logic [7:0] latch_byte(input req_t r);
        logic [3:0] lo;
        lo = (!r.att && r.ch == 2'd3) ? {1'b0, r.val[2:0]} : r.val[3:0];
        return {1'b1, r.ch, r.att, lo};
    endfunction

    assign push = bus.req_valid && ready_q;
    assign head = mem[rd_ptr];

    // Only tone dividers carry a data byte; it is dropped when the chip already holds those high bits.
    assign need_data = work_tone &&
                       !((SKIP_HI != 0) && shadow_valid[work_ch] && (shadow_hi[work_ch] == work_hi));

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ch: bus.req_ch, att: bus.req_att, val: bus.req_val};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count_next;
            ready_q <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        we_next    = we_q;
        d_next     = d_q;
        pop        = 1'b0;
        shadow_wr  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = LATCH;
                    we_next    = 1'b1;
                    d_next     = latch_byte(head);
                end
            end
            LATCH: begin
                if (bus.clk_en) begin
                    if (need_data) begin
                        state_next = DATA;
                        d_next     = {2'b00, work_hi};
                    end else begin
                        we_next    = 1'b0;
                        state_next = (GAP_TICKS == 0) ? IDLE : GAP;
                        gap_next   = GW'(GAP_TICKS);
                    end
                end
            end
            DATA: begin
                if (bus.clk_en) begin
                    shadow_wr  = 1'b1;
                    we_next    = 1'b0;
                    state_next = (GAP_TICKS == 0) ? IDLE : GAP;
                    gap_next   = GW'(GAP_TICKS);
                end
            end
            GAP: begin
                if (bus.clk_en) begin
                    gap_next = gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            we_q         <= 1'b0;
            d_q          <= 8'h00;
            work_ch      <= '0;
            work_hi      <= '0;
            work_tone    <= 1'b0;
            shadow_valid <= '0;
            shadow_hi    <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
            we_q    <= we_next;
            d_q     <= d_next;
            if (pop) begin
                work_ch   <= head.ch;
                work_hi   <= head.val[9:4];
                work_tone <= !head.att && (head.ch != 2'd3);
            end
            if (shadow_wr) begin
                shadow_hi[work_ch]    <= work_hi;
                shadow_valid[work_ch] <= 1'b1;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.psg_we    = we_q;
    assign bus.psg_d     = d_q;
    assign bus.busy      = (state != IDLE) || (count != '0);
endmodule

// File: tb/tb_sn76489_cmd_writer.sv
// Directed bench for sn76489_cmd_writer: one instance with gap and high-bit skipping,
// one with no gap and no skipping; bytes are captured where we && clk_en.
module tb_sn76489_cmd_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sn76489_cmd_writer_if if0 ();
    sn76489_cmd_writer_if if1 ();

    sn76489_cmd_writer #(.FIFO_DEPTH(4), .GAP_TICKS(32), .SKIP_HI(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    sn76489_cmd_writer #(.FIFO_DEPTH(4), .GAP_TICKS(0), .SKIP_HI(0)) u_dut_ng (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] cap0_d [$];
    int         cap0_t [$];
    logic [7:0] cap1_d [$];
    int         cap1_t [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && if0.psg_we && if0.clk_en) begin
            cap0_d.push_back(if0.psg_d);
            cap0_t.push_back(cyc);
        end
        if (!rst && if1.psg_we && if1.clk_en) begin
            cap1_d.push_back(if1.psg_d);
            cap1_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic [1:0] ch,
                           input logic att, input logic [9:0] val);
        if (sel == 0) begin
            if0.req_valid = v; if0.req_ch = ch; if0.req_att = att; if0.req_val = val;
        end else begin
            if1.req_valid = v; if1.req_ch = ch; if1.req_att = att; if1.req_val = val;
        end
    endtask

    // Returns #1 after the accepting edge.
    task automatic push(input int sel, input logic [1:0] ch, input logic att, input logic [9:0] val);
        logic r;
        r = 1'b0;
        set_req(sel, 1'b1, ch, att, val);
        for (int k = 0; k < 200 && !r; k++) begin
            @(negedge clk);
            r = (sel == 0) ? if0.req_ready : if1.req_ready;
            @(posedge clk);
            #1;
        end
        set_req(sel, 1'b0, 2'd0, 1'b0, 10'd0);
        check("push_accept", r, 1);
    endtask

    task automatic wait_idle(input int sel, input string tag, output int t);
        logic b;
        b = 1'b1;
        for (int k = 0; k < 3000 && b; k++) begin
            @(negedge clk);
            b = (sel == 0) ? if0.busy : if1.busy;
        end
        t = cyc;
        check(tag, b, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cap0_at(input int i);
        return (i < cap0_d.size()) ? cap0_d[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] cap1_at(input int i);
        return (i < cap1_d.size()) ? cap1_d[i] : 8'hxx;
    endfunction

    initial begin
        int         t_idle;
        int         acc;
        logic       rdy;
        logic       ok;
        logic [7:0] exp4 [6];
        exp4 = '{8'hB3, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95};

        rst = 1'b1;
        set_req(0, 1'b0, 2'd0, 1'b0, 10'd0);
        set_req(1, 1'b0, 2'd0, 1'b0, 10'd0);
        if0.clk_en = 1'b0;
        if1.clk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", if0.req_ready, 1);
        check("rst_we",    if0.psg_we,    0);
        check("rst_d",     if0.psg_d,     8'h00);
        check("rst_busy",  if0.busy,      0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: two-byte tone write, latency and 32-tick gap
        if0.clk_en = 1'b1;
        push(0, 2'd0, 1'b0, 10'h1FE);
        @(negedge clk);
        check("t1_we_n1", if0.psg_we, 0);
        @(negedge clk);
        check("t1_we_n2", if0.psg_we, 1);
        check("t1_d_n2",  if0.psg_d,  8'h8E);
        wait_idle(0, "t1_idle", t_idle);
        check("t1_nbytes", cap0_d.size(), 2);
        check("t1_b0", cap0_at(0), 8'h8E);
        check("t1_b1", cap0_at(1), 8'h1F);
        check("t1_gap", (cap0_t.size() == 2) ? t_idle - cap0_t[1] : -1, 33);

        // Test 2: matching high bits skip the data byte
        cap0_d.delete(); cap0_t.delete();
        push(0, 2'd0, 1'b0, 10'h1F3);
        wait_idle(0, "t2_idle", t_idle);
        check("t2_nbytes", cap0_d.size(), 1);
        check("t2_b0", cap0_at(0), 8'h83);
        check("t2_gap", (cap0_t.size() == 1) ? t_idle - cap0_t[0] : -1, 33);

        // Test 2b: no skipping, no gap
        push(1, 2'd0, 1'b0, 10'h1FE);
        push(1, 2'd0, 1'b0, 10'h1F3);
        wait_idle(1, "t2b_idle", t_idle);
        check("t2b_nbytes", cap1_d.size(), 4);
        check("t2b_b0", cap1_at(0), 8'h8E);
        check("t2b_b1", cap1_at(1), 8'h1F);
        check("t2b_b2", cap1_at(2), 8'h83);
        check("t2b_b3", cap1_at(3), 8'h1F);
        check("t2b_sp01", (cap1_t.size() == 4) ? cap1_t[1] - cap1_t[0] : -1, 1);
        check("t2b_sp12", (cap1_t.size() == 4) ? cap1_t[2] - cap1_t[1] : -1, 2);

        // Test 3: attenuation then noise, single bytes separated by a gap
        cap0_d.delete(); cap0_t.delete();
        push(0, 2'd2, 1'b1, 10'h00A);
        push(0, 2'd3, 1'b0, 10'h005);
        wait_idle(0, "t3_idle", t_idle);
        check("t3_nbytes", cap0_d.size(), 2);
        check("t3_b0", cap0_at(0), 8'hDA);
        check("t3_b1", cap0_at(1), 8'hE5);
        check("t3_sp", (cap0_t.size() == 2) ? cap0_t[1] - cap0_t[0] : -1, 34);

        // Test 4: FIFO fills behind a stalled write, order preserved on drain
        cap0_d.delete(); cap0_t.delete();
        if0.clk_en = 1'b0;
        push(0, 2'd1, 1'b1, 10'h003);
        repeat (3) @(posedge clk);
        #1;
        acc = 0;
        set_req(0, 1'b1, 2'd0, 1'b1, 10'd1);
        repeat (20) begin
            @(negedge clk);
            rdy = if0.req_ready;
            @(posedge clk); #1;
            if (rdy && acc < 5) begin
                acc++;
                set_req(0, acc < 5, 2'd0, 1'b1, 10'(acc + 1));
            end
        end
        check("t4_accepted", acc, 4);
        @(negedge clk);
        check("t4_ready_low", if0.req_ready, 0);
        @(posedge clk); #1;
        if0.clk_en = 1'b1;
        for (int k = 0; k < 500 && acc < 5; k++) begin
            @(negedge clk);
            rdy = if0.req_ready;
            @(posedge clk); #1;
            if (rdy) acc++;
        end
        set_req(0, 1'b0, 2'd0, 1'b0, 10'd0);
        check("t4_fifth", acc, 5);
        wait_idle(0, "t4_idle", t_idle);
        check("t4_nbytes", cap0_d.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("t4_order", cap0_at(i), exp4[i]);
        end

        // Test 5: long stall in LATCH, one tick advances to DATA
        cap0_d.delete(); cap0_t.delete();
        if0.clk_en = 1'b0;
        push(0, 2'd1, 1'b0, 10'h2A7);
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            ok = if0.psg_we;
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ok = ok && if0.psg_we && (if0.psg_d == 8'hA7);
        end
        check("t5_hold", ok, 1);
        @(posedge clk); #1;
        if0.clk_en = 1'b1;
        @(posedge clk); #1;
        if0.clk_en = 1'b0;
        @(negedge clk);
        check("t5_data_we", if0.psg_we, 1);
        check("t5_data_d",  if0.psg_d,  8'h2A);
        check("t5_nbytes",  cap0_d.size(), 1);
        check("t5_b0",      cap0_at(0), 8'hA7);

        // Test 6: reset while in DATA clears outputs and shadows
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_we",    if0.psg_we,    0);
        check("t6_d",     if0.psg_d,     8'h00);
        check("t6_ready", if0.req_ready, 1);
        check("t6_busy",  if0.busy,      0);
        @(posedge clk); #1;
        rst = 1'b0;
        cap0_d.delete(); cap0_t.delete();
        if0.clk_en = 1'b1;
        push(0, 2'd0, 1'b0, 10'h1F3);
        wait_idle(0, "t6_idle", t_idle);
        check("t6_nbytes", cap0_d.size(), 2);
        check("t6_b0", cap0_at(0), 8'h83);
        check("t6_b1", cap0_at(1), 8'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
